// File: rtl/food_placement_controller.sv
// Food placement sequencer: random candidates with range/alignment check and occupancy handshake,
// falling back to a raster scan of the whole board when the random tries run out.
module food_placement_controller #(
    parameter int GRID_W    = 25,
    parameter int GRID_H    = 19,
    parameter int CELL      = 25,
    parameter int OFFSET    = 2,
    parameter int MAX_TRIES = 8,
    parameter int SETTLE    = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       place_req,
    input  logic [9:0] rand_x,
    input  logic [9:0] rand_y,
    output logic       query_req,
    output logic [9:0] query_x,
    output logic [9:0] query_y,
    input  logic       query_done,
    input  logic       query_hit,
    output logic [9:0] food_x,
    output logic [9:0] food_y,
    output logic       food_valid,
    output logic       busy,
    output logic       board_full
);

    localparam int XMAX = OFFSET + (GRID_W - 1) * CELL;
    localparam int YMAX = OFFSET + (GRID_H - 1) * CELL;
    localparam int GMAX = (GRID_W > GRID_H) ? GRID_W : GRID_H;
    localparam int TW   = $clog2(MAX_TRIES + 1);
    localparam int SW   = $clog2(SETTLE + 2);
    localparam int CW   = $clog2(GRID_W * GRID_H + 1);

    localparam logic [9:0] OFF10   = 10'(OFFSET);
    localparam logic [9:0] CELL10  = 10'(CELL);
    localparam logic [9:0] XMAX10  = 10'(XMAX);
    localparam logic [9:0] YMAX10  = 10'(YMAX);
    localparam logic [9:0] XWRAP10 = 10'(XMAX - CELL);
    localparam logic [9:0] YWRAP10 = 10'(YMAX - CELL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_SAMPLE,
        S_QUERY,
        S_SCAN
    } state_t;

    state_t          state, state_next;
    logic [TW-1:0]   tries;
    logic [SW-1:0]   settle_cnt;
    logic [CW-1:0]   scan_cnt;
    logic            in_scan;
    logic            have_legal;
    logic [9:0]      cand_x, cand_y;
    logic [9:0]      last_x, last_y;
    logic            sample_ok, fail_try, last_try, commit, full;

    // Alignment is a compare bank against the constant cell origins, so no divider is needed.
    function automatic logic on_grid(input logic [9:0] v, input logic [9:0] vmax, input int cells);
        logic aligned;
        aligned = 1'b0;
        for (int i = 0; i < GMAX; i++)
            if (i < cells && v == 10'(OFFSET + i * CELL)) aligned = 1'b1;
        return (v >= OFF10) && (v <= vmax) && aligned;
    endfunction

    assign last_try = (tries == TW'(MAX_TRIES - 1));

    always_ff @(posedge clock) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next = state;
        sample_ok  = on_grid(rand_x, XMAX10, GRID_W) && on_grid(rand_y, YMAX10, GRID_H);
        fail_try   = 1'b0;
        commit     = 1'b0;
        full       = 1'b0;
        busy       = (state != S_IDLE);
        query_req  = (state == S_QUERY);
        query_x    = (state == S_QUERY) ? cand_x : '0;
        query_y    = (state == S_QUERY) ? cand_y : '0;
        case (state)
            S_IDLE:   if (place_req) state_next = S_SETTLE;
            S_SETTLE: if (settle_cnt <= SW'(1)) state_next = S_SAMPLE;
            S_SAMPLE: begin
                if (sample_ok) state_next = S_QUERY;
                else           fail_try   = 1'b1;
            end
            S_QUERY: begin
                if (query_done) begin
                    if (!query_hit) begin
                        commit     = 1'b1;
                        state_next = S_IDLE;
                    end else if (!in_scan) begin
                        fail_try = 1'b1;
                    end else if (scan_cnt == '0) begin
                        full       = 1'b1;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_SCAN;
                    end
                end
            end
            S_SCAN:   state_next = S_QUERY;
            default:  state_next = S_IDLE;
        endcase
        if (fail_try) state_next = last_try ? S_SCAN : S_SETTLE;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            tries      <= '0;
            settle_cnt <= '0;
            scan_cnt   <= '0;
            in_scan    <= 1'b0;
            have_legal <= 1'b0;
            food_x     <= '0;
            food_y     <= '0;
            food_valid <= 1'b0;
            board_full <= 1'b0;
        end else begin
            if (state == S_IDLE && place_req) begin
                food_valid <= 1'b0;
                tries      <= '0;
                settle_cnt <= SW'(SETTLE);
                in_scan    <= 1'b0;
                have_legal <= 1'b0;
            end
            if (state == S_SETTLE) settle_cnt <= settle_cnt - SW'(1);
            if (state == S_SAMPLE && sample_ok) begin
                cand_x     <= rand_x;
                cand_y     <= rand_y;
                last_x     <= rand_x;
                last_y     <= rand_y;
                have_legal <= 1'b1;
            end
            if (fail_try) begin
                tries <= tries + TW'(1);
                if (last_try) begin
                    in_scan  <= 1'b1;
                    scan_cnt <= CW'(GRID_W * GRID_H);
                    cand_x   <= have_legal ? last_x : OFF10;
                    cand_y   <= have_legal ? last_y : OFF10;
                end else begin
                    settle_cnt <= SW'(SETTLE);
                end
            end
            // Wrap tests run on the current value so the 10-bit add never overflows.
            if (state == S_SCAN) begin
                scan_cnt <= scan_cnt - CW'(1);
                if (cand_x > XWRAP10) begin
                    cand_x <= OFF10;
                    cand_y <= (cand_y > YWRAP10) ? OFF10 : cand_y + CELL10;
                end else begin
                    cand_x <= cand_x + CELL10;
                end
            end
            if (commit) begin
                food_x     <= cand_x;
                food_y     <= cand_y;
                food_valid <= 1'b1;
            end
            if (full) board_full <= 1'b1;
        end
    end

endmodule

// File: tb/tb_food_placement_controller.sv
// Bench for food_placement_controller: an occupancy-map body store answers queries and a
// cell-index reference model predicts the query sequence and the placement outcome.
module tb_food_placement_controller;

    localparam int GW = 25, GH = 19, CELL = 25, OFF = 2, TRIES = 8, NC = GW * GH;
    localparam int XMAX = OFF + (GW - 1) * CELL;
    localparam int YMAX = OFF + (GH - 1) * CELL;

    logic       clock = 1'b0, reset = 1'b1, place_req = 1'b0;
    logic       query_done = 1'b0, query_hit = 1'b0;
    logic [9:0] rand_x = '0, rand_y = '0;
    logic       query_req, food_valid, busy, board_full;
    logic [9:0] query_x, query_y, food_x, food_y;

    int vectors = 0, miscompares = 0;
    bit occ [NC];
    int px [TRIES], py [TRIES];
    logic [9:0] qx [$], qy [$], ex [$], ey [$];
    bit   exp_full, bf_model;
    logic [9:0] exp_fx, exp_fy;
    bit   timed_out, fv_busy, unstable;
    logic busy_start;

    food_placement_controller #(.GRID_W(GW), .GRID_H(GH), .CELL(CELL), .OFFSET(OFF),
                                .MAX_TRIES(TRIES), .SETTLE(2)) dut (
        .clock(clock), .reset(reset), .place_req(place_req),
        .rand_x(rand_x), .rand_y(rand_y),
        .query_req(query_req), .query_x(query_x), .query_y(query_y),
        .query_done(query_done), .query_hit(query_hit),
        .food_x(food_x), .food_y(food_y), .food_valid(food_valid),
        .busy(busy), .board_full(board_full)
    );

    always #5 clock = ~clock;

    function automatic bit is_legal(input int v, input int lim);
        return v >= OFF && v <= lim && ((v - OFF) % CELL) == 0;
    endfunction

    function automatic int px_of(input int idx);
        return OFF + (idx % GW) * CELL;
    endfunction

    function automatic int py_of(input int idx);
        return OFF + (idx / GW) * CELL;
    endfunction

    function automatic bit occupied(input int x, input int y);
        if (!(is_legal(x, XMAX) && is_legal(y, YMAX))) return 1'b0;
        return occ[((y - OFF) / CELL) * GW + (x - OFF) / CELL];
    endfunction

    // Reference: random tries by cell index, then a linear row-major scan modulo board size.
    function automatic void run_model();
        int k, last, start, idx;
        k = 0; last = -1;
        ex.delete(); ey.delete(); exp_full = 1'b0;
        for (int t = 0; t < TRIES; t++) begin
            if (is_legal(px[k], XMAX) && is_legal(py[k], YMAX)) begin
                last = ((py[k] - OFF) / CELL) * GW + (px[k] - OFF) / CELL;
                ex.push_back(10'(px[k])); ey.push_back(10'(py[k]));
                if (!occ[last]) begin
                    exp_fx = 10'(px[k]); exp_fy = 10'(py[k]);
                    return;
                end
                if (k < TRIES - 1) k++;
            end
        end
        start = (last < 0) ? 0 : last;
        for (int n = 1; n <= NC; n++) begin
            idx = (start + n) % NC;
            ex.push_back(10'(px_of(idx))); ey.push_back(10'(py_of(idx)));
            if (!occ[idx]) begin
                exp_fx = 10'(px_of(idx)); exp_fy = 10'(py_of(idx));
                return;
            end
        end
        exp_full = 1'b1;
        bf_model = 1'b1;
    endfunction

    // Acts as game FSM, random source and body store for one placement; records what it saw.
    task automatic serve(input int max_cycles, input int lmin, input int lmax);
        int k, lat, cyc;
        bit inq;
        logic [9:0] hx, hy;
        qx.delete(); qy.delete();
        timed_out = 0; fv_busy = 0; unstable = 0;
        k = 0; lat = 0; cyc = 0; inq = 0; hx = '0; hy = '0;
        rand_x = 10'(px[0]); rand_y = 10'(py[0]);
        @(negedge clock); place_req = 1'b1;
        @(negedge clock); place_req = 1'b0;
        busy_start = busy;
        while (busy && !timed_out) begin
            query_done = 1'b0; query_hit = 1'($urandom); place_req = 1'b0;
            if (food_valid) fv_busy = 1;
            if (query_req) begin
                if (!inq) begin
                    inq = 1; hx = query_x; hy = query_y;
                    qx.push_back(hx); qy.push_back(hy);
                    lat = int'($urandom_range(lmax, lmin));
                end else if (query_x !== hx || query_y !== hy) begin
                    unstable = 1;
                end
                if (lat == 0) begin
                    query_done = 1'b1; query_hit = occupied(int'(hx), int'(hy)); inq = 0;
                    if (k < TRIES - 1) k++;
                    rand_x = 10'(px[k]); rand_y = 10'(py[k]);
                end else begin
                    lat--;
                end
            end
            if (!query_done) place_req = ($urandom_range(7, 0) == 0);
            @(negedge clock); cyc++;
            if (cyc >= max_cycles) timed_out = 1;
        end
        query_done = 1'b0; place_req = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; place_req = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0; place_req = 1'b0; bf_model = 0;
        vectors++; if (food_x !== 10'd0) begin miscompares++; $display("FAIL rst_food_x: got %0d want 0", food_x); end
        vectors++; if (food_y !== 10'd0) begin miscompares++; $display("FAIL rst_food_y: got %0d want 0", food_y); end
        vectors++; if (food_valid !== 1'b0) begin miscompares++; $display("FAIL rst_food_valid: got %b want 0", food_valid); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b want 0", busy); end
        vectors++; if (query_req !== 1'b0) begin miscompares++; $display("FAIL rst_query_req: got %b want 0", query_req); end
        vectors++; if (query_x !== 10'd0 || query_y !== 10'd0) begin miscompares++; $display("FAIL rst_query_xy: got %0d,%0d want 0,0", query_x, query_y); end
        vectors++; if (board_full !== 1'b0) begin miscompares++; $display("FAIL rst_board_full: got %b want 0", board_full); end
        @(negedge clock);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL rst_place_dropped: busy %b want 0", busy); end
    endtask

    task automatic test_basic();
        for (int c = 0; c < NC; c++) occ[c] = 0;
        for (int i = 0; i < TRIES; i++) begin px[i] = 52; py[i] = 77; end
        run_model();
        serve(200, 2, 2);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL basic_timeout: got 1 want 0"); end
        vectors++; if (busy_start !== 1'b1) begin miscompares++; $display("FAIL basic_busy_rise: got %b want 1", busy_start); end
        vectors++; if (qx.size() != 1) begin miscompares++; $display("FAIL basic_nq: got %0d want 1", qx.size()); end
        else begin
            vectors++; if (qx[0] !== 10'd52 || qy[0] !== 10'd77) begin miscompares++; $display("FAIL basic_query: got %0d,%0d want 52,77", qx[0], qy[0]); end
        end
        vectors++; if (unstable) begin miscompares++; $display("FAIL basic_query_hold: got 1 want 0"); end
        vectors++; if (fv_busy) begin miscompares++; $display("FAIL basic_fv_early: got 1 want 0"); end
        vectors++; if (food_valid !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL basic_commit: valid %b busy %b want 1 0", food_valid, busy); end
        vectors++; if (food_x !== 10'd52 || food_y !== 10'd77) begin miscompares++; $display("FAIL basic_food: got %0d,%0d want 52,77", food_x, food_y); end
    endtask

    task automatic test_misaligned();
        for (int c = 0; c < NC; c++) occ[c] = 0;
        for (int i = 0; i < TRIES; i++) begin px[i] = 27; py[i] = 17; end
        run_model();
        serve(400, 0, 2);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL mis_timeout: got 1 want 0"); end
        vectors++; if (qx.size() != 1) begin miscompares++; $display("FAIL mis_nq: got %0d want 1", qx.size()); end
        else begin
            vectors++; if (qx[0] !== 10'd27 || qy[0] !== 10'd2) begin miscompares++; $display("FAIL mis_first_scan: got %0d,%0d want 27,2", qx[0], qy[0]); end
        end
        vectors++; if (food_valid !== 1'b1 || food_x !== 10'd27 || food_y !== 10'd2) begin miscompares++; $display("FAIL mis_food: got %b %0d,%0d want 1 27,2", food_valid, food_x, food_y); end
    endtask

    task automatic test_retry();
        int base;
        base = int'($urandom_range(NC - 1, 0));
        for (int c = 0; c < NC; c++) occ[c] = 0;
        for (int i = 0; i < TRIES; i++) begin
            px[i] = px_of((base + 37 * i) % NC); py[i] = py_of((base + 37 * i) % NC);
            if (i < 3) occ[(base + 37 * i) % NC] = 1;
        end
        run_model();
        serve(400, 0, 2);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL retry_timeout: got 1 want 0"); end
        vectors++; if (qx.size() != 4) begin miscompares++; $display("FAIL retry_nq: got %0d want 4", qx.size()); end
        for (int i = 0; i < 4 && i < qx.size(); i++) begin
            vectors++; if (qx[i] !== ex[i] || qy[i] !== ey[i]) begin miscompares++; $display("FAIL retry_q%0d: got %0d,%0d want %0d,%0d", i, qx[i], qy[i], ex[i], ey[i]); end
        end
        vectors++; if (food_valid !== 1'b1 || food_x !== 10'(px[3]) || food_y !== 10'(py[3])) begin miscompares++; $display("FAIL retry_food: got %b %0d,%0d want 1 %0d,%0d", food_valid, food_x, food_y, px[3], py[3]); end
        vectors++; if (board_full !== 1'b0) begin miscompares++; $display("FAIL retry_full: got %b want 0", board_full); end
    endtask

    task automatic test_wrap();
        int base;
        base = int'($urandom_range(100, 1));
        for (int c = 0; c < NC; c++) occ[c] = 0;
        for (int i = 0; i < TRIES; i++) begin
            if (i < TRIES - 1) begin px[i] = px_of(base + 37 * i); py[i] = py_of(base + 37 * i); end
            else begin px[i] = XMAX; py[i] = YMAX; end
            occ[((py[i] - OFF) / CELL) * GW + (px[i] - OFF) / CELL] = 1;
        end
        run_model();
        serve(600, 0, 2);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL wrap_timeout: got 1 want 0"); end
        vectors++; if (qx.size() != 9) begin miscompares++; $display("FAIL wrap_nq: got %0d want 9", qx.size()); end
        else begin
            vectors++; if (qx[8] !== 10'd2 || qy[8] !== 10'd2) begin miscompares++; $display("FAIL wrap_scan: got %0d,%0d want 2,2", qx[8], qy[8]); end
        end
        vectors++; if (food_valid !== 1'b1 || food_x !== 10'd2 || food_y !== 10'd2) begin miscompares++; $display("FAIL wrap_food: got %b %0d,%0d want 1 2,2", food_valid, food_x, food_y); end
    endtask

    task automatic test_random();
        int density;
        for (int it = 0; it < 8; it++) begin
            density = int'($urandom_range(50, 0));
            for (int c = 0; c < NC; c++) occ[c] = ($urandom_range(99, 0) < density);
            for (int i = 0; i < TRIES; i++) begin
                if ($urandom_range(3, 0) == 0) begin
                    px[i] = int'($urandom_range(1023, 0)); py[i] = int'($urandom_range(1023, 0));
                end else begin
                    px[i] = px_of(int'($urandom_range(NC - 1, 0))); py[i] = py_of(int'($urandom_range(NC - 1, 0)));
                end
            end
            run_model();
            serve(8000, 0, 2);
            vectors++; if (timed_out) begin miscompares++; $display("FAIL rnd%0d_timeout: got 1 want 0", it); end
            vectors++; if (qx.size() != ex.size()) begin miscompares++; $display("FAIL rnd%0d_nq: got %0d want %0d", it, qx.size(), ex.size()); end
            for (int i = 0; i < ex.size() && i < qx.size(); i++) begin
                vectors++; if (qx[i] !== ex[i] || qy[i] !== ey[i]) begin miscompares++; $display("FAIL rnd%0d_q%0d: got %0d,%0d want %0d,%0d", it, i, qx[i], qy[i], ex[i], ey[i]); end
            end
            vectors++; if (food_valid !== !exp_full) begin miscompares++; $display("FAIL rnd%0d_valid: got %b want %b", it, food_valid, !exp_full); end
            if (!exp_full) begin
                vectors++; if (food_x !== exp_fx || food_y !== exp_fy) begin miscompares++; $display("FAIL rnd%0d_food: got %0d,%0d want %0d,%0d", it, food_x, food_y, exp_fx, exp_fy); end
            end
            vectors++; if (board_full !== bf_model) begin miscompares++; $display("FAIL rnd%0d_full: got %b want %b", it, board_full, bf_model); end
            vectors++; if (unstable || fv_busy) begin miscompares++; $display("FAIL rnd%0d_protocol: hold %b early_valid %b want 0 0", it, unstable, fv_busy); end
        end
    endtask

    task automatic test_full();
        for (int c = 0; c < NC; c++) occ[c] = 1;
        for (int i = 0; i < TRIES; i++) begin
            px[i] = px_of(int'($urandom_range(NC - 1, 0))); py[i] = py_of(int'($urandom_range(NC - 1, 0)));
        end
        run_model();
        serve(20000, 0, 1);
        vectors++; if (timed_out) begin miscompares++; $display("FAIL full_timeout: got 1 want 0"); end
        vectors++; if (qx.size() != 483) begin miscompares++; $display("FAIL full_nq: got %0d want 483", qx.size()); end
        for (int i = 0; i < ex.size() && i < qx.size(); i++) begin
            vectors++; if (qx[i] !== ex[i] || qy[i] !== ey[i]) begin miscompares++; $display("FAIL full_q%0d: got %0d,%0d want %0d,%0d", i, qx[i], qy[i], ex[i], ey[i]); end
        end
        vectors++; if (board_full !== 1'b1) begin miscompares++; $display("FAIL full_flag: got %b want 1", board_full); end
        vectors++; if (food_valid !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL full_outputs: valid %b busy %b want 0 0", food_valid, busy); end
    endtask

    task automatic test_reset_mid();
        bit seen;
        seen = 0;
        for (int c = 0; c < NC; c++) occ[c] = 0;
        for (int i = 0; i < TRIES; i++) begin px[i] = 52; py[i] = 77; end
        rand_x = 10'd52; rand_y = 10'd77;
        @(negedge clock); place_req = 1'b1;
        @(negedge clock); place_req = 1'b0;
        for (int i = 0; i < 30 && !seen; i++) begin
            if (query_req) seen = 1;
            else @(negedge clock);
        end
        vectors++; if (!seen) begin miscompares++; $display("FAIL mid_query_seen: got 0 want 1"); end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0; query_done = 1'b1; query_hit = 1'b0; bf_model = 0;
        @(negedge clock);
        query_done = 1'b0;
        vectors++; if (query_req !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL mid_ctrl: req %b busy %b want 0 0", query_req, busy); end
        vectors++; if (food_valid !== 1'b0 || food_x !== 10'd0 || food_y !== 10'd0) begin miscompares++; $display("FAIL mid_food: got %b %0d,%0d want 0 0,0", food_valid, food_x, food_y); end
        vectors++; if (board_full !== 1'b0) begin miscompares++; $display("FAIL mid_full: got %b want 0", board_full); end
        repeat (3) @(negedge clock);
        vectors++; if (food_valid !== 1'b0) begin miscompares++; $display("FAIL mid_late_commit: got %b want 0", food_valid); end
        run_model();
        serve(200, 0, 2);
        vectors++; if (food_valid !== 1'b1 || food_x !== 10'd52 || food_y !== 10'd77) begin miscompares++; $display("FAIL mid_replace: got %b %0d,%0d want 1 52,77", food_valid, food_x, food_y); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_misaligned();
        test_retry();
        test_wrap();
        test_random();
        test_full();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
